// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART transmit path: FSM state encoding and
// parity-type selectors.
package uart_tx_pkg;

    // Frame FSM state encoding
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    // Parity type select (PAR_TYP input)
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator: even parity makes the total count of ones
// (data + parity) even, odd parity makes it odd.
module uart_parity_calc
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    // Reduction XOR of the word, inverted for odd parity
    always_comb begin
        par_bit = ^data;
        case (par_typ)
            PAR_EVEN: par_bit = ^data;
            PAR_ODD:  par_bit = ~^data;
        endcase
    end

endmodule

// File: rtl/uart_tx_frame_serializer.sv
// UART transmit frame engine. Sends start bit, DATA_WIDTH data bits LSB
// first, optional parity and STOP_BITS stop bits, advancing one bit per TICK.
// The word, parity enable and parity bit are captured at acceptance so host
// changes during a frame have no effect. A word presented on the final stop
// tick is accepted directly, giving back-to-back frames with no idle gap.
module uart_tx_frame_serializer
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  TICK,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  DATA_ACK,
    output logic                  BUSY,
    output logic                  TX_OUT
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

    // Reject illegal configurations at elaboration
    generate
        if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
            $error("uart_tx_frame_serializer: DATA_WIDTH must be 5..9");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_tx_frame_serializer: STOP_BITS must be 1 or 2");
        end
    endgenerate

    logic [2:0]            state;
    logic [CNT_W-1:0]      bit_cnt;    // data-bit index in DATA, stop-bit index in STOP
    logic [DATA_WIDTH-1:0] shreg;      // remaining data bits, next one at [0]
    logic                  par_en_q;
    logic                  par_q;
    logic                  par_bit;
    logic                  last_stop;
    logic                  accept;

    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data    (P_DATA),
        .par_typ (PAR_TYP),
        .par_bit (par_bit)
    );

    // A word is taken on a tick in IDLE or on the final stop-bit tick
    always_comb begin
        last_stop = (state == STOP) && (bit_cnt == LAST_STOP);
        accept    = TICK && DATA_VALID && ((state == IDLE) || last_stop);
    end

    // Frame FSM, bit counter, data shifter and registered serial outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            TX_OUT   <= 1'b1;
            BUSY     <= 1'b0;
            DATA_ACK <= 1'b0;
        end else begin
            DATA_ACK <= 1'b0;
            if (accept) begin
                state    <= START;
                bit_cnt  <= '0;
                shreg    <= P_DATA;
                par_en_q <= PAR_EN;
                par_q    <= par_bit;
                TX_OUT   <= 1'b0;
                BUSY     <= 1'b1;
                DATA_ACK <= 1'b1;
            end else if (TICK) begin
                case (state)
                    START: begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        TX_OUT  <= shreg[0];
                        shreg   <= shreg >> 1;
                    end
                    DATA: begin
                        if (bit_cnt != LAST_DATA) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            TX_OUT  <= shreg[0];
                            shreg   <= shreg >> 1;
                        end else if (par_en_q) begin
                            state  <= PARITY;
                            TX_OUT <= par_q;
                        end else begin
                            state   <= STOP;
                            bit_cnt <= '0;
                            TX_OUT  <= 1'b1;
                        end
                    end
                    PARITY: begin
                        state   <= STOP;
                        bit_cnt <= '0;
                        TX_OUT  <= 1'b1;
                    end
                    STOP: begin
                        if (bit_cnt != LAST_STOP) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end else begin
                            state   <= IDLE;
                            bit_cnt <= '0;
                            BUSY    <= 1'b0;
                        end
                        TX_OUT <= 1'b1;
                    end
                    default: begin
                        // IDLE, or recovery from an unused encoding
                        state   <= IDLE;
                        bit_cnt <= '0;
                        TX_OUT  <= 1'b1;
                        BUSY    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Directed bench for uart_tx_frame_serializer: one instance with one stop
// bit, one with two. Expected frames are written out bit by bit as literals
// {stop.., parity, data[7:0], start} so frame bit i is vector bit i.
module tb_uart_tx_frame_serializer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       TICK;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       ack1, busy1, tx1;
    logic       ack2, busy2, tx2;

    int checks   = 0;
    int errors   = 0;
    int tick_per = 1;
    int ccount   = 0;

    always #5 CLK = ~CLK;

    uart_tx_frame_serializer #(.DATA_WIDTH(8), .STOP_BITS(1)) dut1 (
        .CLK(CLK), .RST(RST), .TICK(TICK), .P_DATA(P_DATA),
        .DATA_VALID(DATA_VALID), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .DATA_ACK(ack1), .BUSY(busy1), .TX_OUT(tx1)
    );

    uart_tx_frame_serializer #(.DATA_WIDTH(8), .STOP_BITS(2)) dut2 (
        .CLK(CLK), .RST(RST), .TICK(TICK), .P_DATA(P_DATA),
        .DATA_VALID(DATA_VALID), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .DATA_ACK(ack2), .BUSY(busy2), .TX_OUT(tx2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; sample point is 1 time unit after the edge, then TICK is
    // set for the following edge from a free-running cycle count.
    task automatic cyc();
        @(posedge CLK);
        #1;
        ccount++;
        TICK = ((ccount % tick_per) == 0);
    endtask

    function automatic logic tx_of(input bit s);
        return s ? tx2 : tx1;
    endfunction
    function automatic logic busy_of(input bit s);
        return s ? busy2 : busy1;
    endfunction
    function automatic logic ack_of(input bit s);
        return s ? ack2 : ack1;
    endfunction

    // Present a word, wait (bounded) for its ACK, scramble the host inputs,
    // then check every bit for tick_per cycles and the return to idle.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic pe,
                             input logic pt, input int nb, input logic [15:0] exp,
                             input bit s);
        bit got = 1'b0;
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; DATA_VALID = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            cyc();
            got = ack_of(s);
        end
        chk({tag, " ack"}, got, 1);
        DATA_VALID = 1'b0; P_DATA = ~d; PAR_EN = ~pe; PAR_TYP = ~pt;
        for (int i = 0; i < nb; i++) begin
            for (int j = 0; j < tick_per; j++) begin
                chk($sformatf("%s tx bit%0d c%0d", tag, i, j), tx_of(s), exp[i]);
                chk($sformatf("%s busy bit%0d c%0d", tag, i, j), busy_of(s), 1);
                chk($sformatf("%s ackpulse bit%0d c%0d", tag, i, j), ack_of(s), (i == 0 && j == 0));
                cyc();
            end
        end
        chk({tag, " end busy"}, busy_of(s), 0);
        chk({tag, " end tx"}, tx_of(s), 1);
        chk({tag, " end ack"}, ack_of(s), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] exp4;
        bit got;

        // Reset state
        RST = 1'b1; TICK = 1'b1; DATA_VALID = 1'b0; P_DATA = 8'h00;
        PAR_EN = 1'b0; PAR_TYP = 1'b0;
        cyc(); cyc();
        chk("rst tx1", tx1, 1);
        chk("rst busy1", busy1, 0);
        chk("rst ack1", ack1, 0);
        chk("rst tx2", tx2, 1);
        chk("rst busy2", busy2, 0);
        RST = 1'b0;
        cyc();

        // 1: 0xA5 even parity -> parity 0
        run_frame("t1", 8'hA5, 1'b1, 1'b0, 11, 16'(11'b1_0_10100101_0), 1'b0);
        cyc();
        // 2: 0xA5 odd parity -> parity 1
        run_frame("t2", 8'hA5, 1'b1, 1'b1, 11, 16'(11'b1_1_10100101_0), 1'b0);
        cyc();

        // 3: two stop bits, no parity, 0x00
        RST = 1'b1;
        cyc();
        chk("t3 rst tx2", tx2, 1);
        chk("t3 rst busy2", busy2, 0);
        RST = 1'b0;
        cyc();
        run_frame("t3", 8'h00, 1'b0, 1'b0, 11, 16'(11'b11_00000000_0), 1'b1);
        cyc();

        // 4: back-to-back 0x55 then 0x0F with DATA_VALID held
        P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            cyc();
            got = ack1;
        end
        chk("t4 ack", got, 1);
        P_DATA = 8'h0F;
        exp4 = {10'b1_00001111_0, 10'b1_01010101_0};
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("t4 tx bit%0d", i), tx1, exp4[i]);
            chk($sformatf("t4 busy bit%0d", i), busy1, 1);
            chk($sformatf("t4 ackpulse bit%0d", i), ack1, (i == 0 || i == 10));
            if (i == 10) DATA_VALID = 1'b0;
            cyc();
        end
        chk("t4 end busy", busy1, 0);
        chk("t4 end tx", tx1, 1);

        // 5: TICK every 4th cycle; DATA_VALID raised between ticks
        tick_per = 4;
        cyc();
        for (int k = 0; k < 4 && TICK; k++) cyc();
        P_DATA = 8'h3C; PAR_EN = 1'b0; DATA_VALID = 1'b1;
        cyc();
        chk("t5 no ack off-tick", ack1, 0);
        chk("t5 idle off-tick", busy1, 0);
        chk("t5 tx off-tick", tx1, 1);
        run_frame("t5", 8'h3C, 1'b0, 1'b0, 10, 16'(10'b1_00111100_0), 1'b0);

        // 6: reset during data bit 3, then a clean 0x81 odd-parity frame
        tick_per = 1;
        cyc();
        P_DATA = 8'hF0; PAR_EN = 1'b0; DATA_VALID = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            cyc();
            got = ack1;
        end
        chk("t6 ack", got, 1);
        DATA_VALID = 1'b0;
        for (int k = 0; k < 4; k++) cyc();
        chk("t6 data bit3", tx1, 0);
        chk("t6 busy mid", busy1, 1);
        RST = 1'b1;
        cyc();
        chk("t6 rst tx", tx1, 1);
        chk("t6 rst busy", busy1, 0);
        chk("t6 rst ack", ack1, 0);
        RST = 1'b0;
        run_frame("t6", 8'h81, 1'b1, 1'b1, 11, 16'(11'b1_1_10000001_0), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
